store_buffer: RTL and testbench
===============================

Name: store_buffer

Overview:
- Store-side counterpart to the writeback result select, which consumes memory read data; this block owns the write path into data memory.
- Accepts store requests from the execute/memory stage and aligns the data to byte lanes.
- Generates byte enables and queues stores in a small FIFO.
- Drains the FIFO to data memory over a req/ack handshake, so stores do not stall the core unless the buffer is full.

Parameters:
- DEPTH, 4, number of buffered stores (power of two, ≥2)
- AW, 32, address width
- DW, 32, data width (fixed 32; byte lanes = 4)

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- st_valid  input  1  store request from pipeline
- st_addr  input  AW  byte address
- st_data  input  DW  register rs2 value
- st_funct3  input  3  000=SB, 001=SH, 010=SW; others illegal
- st_ready  output  1  buffer can accept (not full)
- st_err  output  1  one-cycle pulse: misaligned or illegal store rejected
- mem_req  output  1  write request to data memory
- mem_addr  output  AW  word-aligned address {addr[AW-1:2],2'b00}
- mem_wdata  output  DW  lane-replicated write data
- mem_be  output  4  byte enables
- mem_ack  input  1  memory accepted current write
- drained  output  1  FIFO empty and drain FSM idle (used by fence)

Behaviour:
- Reset (async, immediate): FIFO count=0, pointers=0, FSM=IDLE, st_ready=1, st_err=0, mem_req=0, mem_addr/mem_wdata/mem_be=0, drained=1.
- Accept condition: st_valid && st_ready && legal. st_ready = (count != DEPTH), from registered count only; no combinational dependence on mem_ack.
- Legality:
  - SB: any address.
  - SH: addr[0]==0.
  - SW: addr[1:0]==00.
  - funct3 not in {000,001,010} is illegal.
- Illegal request with st_valid && st_ready: not enqueued; st_err=1 the following cycle for exactly one cycle.
- Request with st_valid && !st_ready: ignored, no error; pipeline holds it.
- Alignment, computed at enqueue and stored per entry:
  - SB: wdata = {4{data[7:0]}}, be = 4'b0001 << addr[1:0].
  - SH: wdata = {2{data[15:0]}}, be = addr[1] ? 1100 : 0011.
  - SW: wdata = data, be = 1111.
- Entry contents: word address, wdata, be.
- Drain FSM states IDLE and REQ:
  - IDLE: mem_req=0. If count!=0, go to REQ next cycle.
  - REQ: mem_req=1. mem_addr/wdata/be come from the head entry and stay stable until mem_ack.
  - On mem_ack in REQ: pop head. If count after pop is nonzero, stay in REQ and present the next entry the following cycle. Otherwise go to IDLE.
  - mem_ack outside REQ is ignored.
- Latency: store accepted into an empty buffer in cycle N gives mem_req=1 in cycle N+2 (N+1 write, FSM leaves IDLE). A zero-wait memory sustains one write per cycle while in REQ.
- Push and pop in the same cycle: count unchanged, both pointers advance. Allowed at full: st_ready reflects pre-pop count, so a push at full is refused even if an ack occurs.
- Pointers wrap modulo DEPTH.
- Ordering: strict FIFO; writes reach memory in acceptance order.
- drained = (count==0) && (FSM==IDLE).
- Reset mid-REQ: mem_req drops asynchronously; all pending stores are discarded.

Decomposition:
- Shared package core_pkg holds:
  - funct3 store encodings (F3_SB, F3_SH, F3_SW);
  - typedef store_entry_t {addr, wdata, be};
  - drain FSM enum {IDLE, REQ}.
- One natural sub-module: sync_fifo (parameterised depth/width, push/pop/count/full/empty). Alignment and FSM stay in store_buffer.

Test Plan:
- SB addr 0x0000_1003, data 0x0000_00AB, mem_ack=1 when req → mem_req two cycles after accept, mem_addr 0x0000_1000, be=1000, wdata 0xABABABAB, drained=1 the cycle after ack.
- SH addr 0x2002, data 0x0000_1234 → be=1100, wdata 0x12341234. Then SH addr 0x2001 → st_err one-cycle pulse, nothing enqueued, mem_req stays 0.
- mem_ack held 0, four SW to 0x10,0x14,0x18,0x1C → st_ready=0 after the 4th. A 5th request is held and not lost. Then ack every cycle → writes in order 0x10..0x1C, st_ready returns 1 the cycle after the first ack, and the 5th store drains last.
- Buffer full, st_valid=1 and mem_ack=1 in the same cycle → push refused, one pop, count=3; next cycle push accepted, count=3.
- Assert rst while mem_req=1 with 2 entries queued → mem_req=0 and drained=1 immediately, with no clock edge. After release, no stale writes are issued.
- st_funct3=011 (SD) addr 0x0 → st_err pulse, no enqueue; legal SB the next cycle is accepted normally.

Source files
------------

// File: rtl/core_pkg.sv
// Shared definitions for the store path: funct3 store encodings, the buffered
// entry layout and the drain FSM state type.
package core_pkg;

  localparam int SB_AW   = 32;
  localparam int SB_DW   = 32;
  localparam int SB_BE_W = SB_DW / 8;

  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

  typedef struct packed {
    logic [SB_AW-1:0]   addr;
    logic [SB_DW-1:0]   wdata;
    logic [SB_BE_W-1:0] be;
  } store_entry_t;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } drain_state_t;

  // Natural alignment: halfwords on even addresses, words on multiples of four.
  function automatic logic store_legal(input logic [2:0] funct3, input logic [1:0] addr_lo);
    logic ok;
    ok = 1'b0;
    case (funct3)
      F3_SB:   ok = 1'b1;
      F3_SH:   ok = ~addr_lo[0];
      F3_SW:   ok = (addr_lo == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; push is ignored when full and pop
// when empty. Read data is the head entry, available combinationally.
module sync_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 8,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // NOTE: storage is not reset; count and pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Store buffer: validates and lane-aligns pipeline stores, queues them, and
// drains them in order to data memory over a req/ack handshake.
module store_buffer
  import core_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = SB_AW,
  parameter int DW    = SB_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          st_valid,
  input  logic [AW-1:0] st_addr,
  input  logic [DW-1:0] st_data,
  input  logic [2:0]    st_funct3,
  output logic          st_ready,
  output logic          st_err,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic [3:0]    mem_be,
  input  logic          mem_ack,
  output logic          drained
);

  localparam int CW = $clog2(DEPTH + 1);

  drain_state_t state, next_state;
  store_entry_t new_entry, head;
  logic [CW-1:0] count;
  logic          full, empty;
  logic          legal, push, pop;

  assign legal    = store_legal(st_funct3, st_addr[1:0]);
  assign st_ready = ~full;
  assign push     = st_valid && st_ready && legal;

  // Alignment is done once at enqueue so the drain side only replays entries.
  always_comb begin
    new_entry      = '0;
    new_entry.addr = SB_AW'({st_addr[AW-1:2], 2'b00});
    case (st_funct3)
      F3_SB: begin
        new_entry.wdata = {4{st_data[7:0]}};
        new_entry.be    = 4'b0001 << st_addr[1:0];
      end
      F3_SH: begin
        new_entry.wdata = {2{st_data[15:0]}};
        new_entry.be    = st_addr[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        new_entry.wdata = SB_DW'(st_data);
        new_entry.be    = 4'b1111;
      end
    endcase
  end

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(store_entry_t))
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (new_entry),
    .rdata (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  // NOTE: state and the error flag use non-blocking assignments so every
  // register samples pre-edge values; combinational blocks use blocking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      st_err <= 1'b0;
    end else begin
      state  <= next_state;
      st_err <= st_valid && st_ready && !legal;
    end
  end

  // Memory outputs are decoded from state so a reset drops them without a clock.
  always_comb begin
    next_state = state;
    pop        = 1'b0;
    mem_req    = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_be     = '0;
    case (state)
      IDLE: begin
        if (!empty) next_state = REQ;
      end
      REQ: begin
        mem_req   = 1'b1;
        mem_addr  = AW'(head.addr);
        mem_wdata = DW'(head.wdata);
        mem_be    = head.be;
        if (mem_ack) begin
          pop = 1'b1;
          // Occupancy after this edge is count - 1 + push.
          if (!((count > CW'(1)) || push)) next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  assign drained = empty && (state == IDLE);

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: inputs change and outputs are sampled on
// the falling edge; the DUT acts on the rising edge.
module tb_store_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        st_valid;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [2:0]  st_funct3;
  logic        st_ready;
  logic        st_err;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic        drained;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  store_buffer #(.DEPTH(4), .AW(32), .DW(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .st_valid  (st_valid),
    .st_addr   (st_addr),
    .st_data   (st_data),
    .st_funct3 (st_funct3),
    .st_ready  (st_ready),
    .st_err    (st_err),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .mem_ack   (mem_ack),
    .drained   (drained)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] d, input logic [2:0] f);
    st_valid  = v;
    st_addr   = a;
    st_data   = d;
    st_funct3 = f;
  endtask

  task automatic test_reset();
    rst = 1'b1; mem_ack = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 3'b000);
    #2;
    checks++; if (st_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", st_ready); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", mem_req); end
    checks++; if (drained !== 1'b1) begin errors++; $display("FAIL reset_drained: got %b want 1", drained); end
    checks++; if (st_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", st_err); end
    checks++; if ({mem_addr, mem_wdata, mem_be} !== 68'h0) begin errors++; $display("FAIL reset_bus: got %h/%h/%b want 0", mem_addr, mem_wdata, mem_be); end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_sb();
    mem_ack = 1'b1;
    drive(1'b1, 32'h0000_1003, 32'h0000_00AB, 3'b000);
    tick();
    drive(1'b0, 32'h0, 32'h0, 3'b000);
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL sb_req_n1: got %b want 0", mem_req); end
    checks++; if (drained !== 1'b0) begin errors++; $display("FAIL sb_drained_n1: got %b want 0", drained); end
    tick();
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL sb_req_n2: got %b want 1", mem_req); end
    checks++; if (mem_addr !== 32'h0000_1000) begin errors++; $display("FAIL sb_addr: got %h want 00001000", mem_addr); end
    checks++; if (mem_be !== 4'b1000) begin errors++; $display("FAIL sb_be: got %b want 1000", mem_be); end
    checks++; if (mem_wdata !== 32'hABAB_ABAB) begin errors++; $display("FAIL sb_wdata: got %h want ababab", mem_wdata); end
    tick();
    checks++; if (drained !== 1'b1) begin errors++; $display("FAIL sb_drained_after_ack: got %b want 1", drained); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL sb_req_after_ack: got %b want 0", mem_req); end
    mem_ack = 1'b0;
  endtask

  task automatic test_sh();
    mem_ack = 1'b0;
    drive(1'b1, 32'h0000_2002, 32'h0000_1234, 3'b001);
    tick();
    drive(1'b0, 32'h0, 32'h0, 3'b000);
    checks++; if (st_err !== 1'b0) begin errors++; $display("FAIL sh_no_err: got %b want 0", st_err); end
    tick();
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL sh_req: got %b want 1", mem_req); end
    checks++; if (mem_be !== 4'b1100) begin errors++; $display("FAIL sh_be: got %b want 1100", mem_be); end
    checks++; if (mem_wdata !== 32'h1234_1234) begin errors++; $display("FAIL sh_wdata: got %h want 12341234", mem_wdata); end
    checks++; if (mem_addr !== 32'h0000_2000) begin errors++; $display("FAIL sh_addr: got %h want 00002000", mem_addr); end
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    checks++; if (drained !== 1'b1) begin errors++; $display("FAIL sh_drained: got %b want 1", drained); end
    drive(1'b1, 32'h0000_2001, 32'h0000_5678, 3'b001);
    tick();
    drive(1'b0, 32'h0, 32'h0, 3'b000);
    checks++; if (st_err !== 1'b1) begin errors++; $display("FAIL sh_mis_err: got %b want 1", st_err); end
    checks++; if (drained !== 1'b1) begin errors++; $display("FAIL sh_mis_not_queued: got %b want 1", drained); end
    tick();
    checks++; if (st_err !== 1'b0) begin errors++; $display("FAIL sh_mis_err_pulse: got %b want 0", st_err); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL sh_mis_req: got %b want 0", mem_req); end
    tick();
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL sh_mis_req2: got %b want 0", mem_req); end
  endtask

  task automatic test_fill_drain();
    logic [31:0] exp_addr [5];
    logic [31:0] exp_data [5];
    for (int i = 0; i < 5; i++) begin
      exp_addr[i] = 32'h10 + 32'(4 * i);
      exp_data[i] = 32'hD000_0000 + 32'(i);
    end
    mem_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++; if (st_ready !== 1'b1) begin errors++; $display("FAIL fill_ready_%0d: got %b want 1", i, st_ready); end
      drive(1'b1, exp_addr[i], exp_data[i], 3'b010);
      tick();
    end
    checks++; if (st_ready !== 1'b0) begin errors++; $display("FAIL fill_full: got %b want 0", st_ready); end
    drive(1'b1, exp_addr[4], exp_data[4], 3'b010);
    tick(); tick();
    checks++; if (st_ready !== 1'b0) begin errors++; $display("FAIL fill_held_ready: got %b want 0", st_ready); end
    checks++; if (mem_addr !== 32'h10) begin errors++; $display("FAIL fill_head_stable: got %h want 00000010", mem_addr); end
    mem_ack = 1'b1;
    for (int k = 0; k < 5; k++) begin
      checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL drain_req_%0d: got %b want 1", k, mem_req); end
      checks++; if (mem_addr !== exp_addr[k]) begin errors++; $display("FAIL drain_addr_%0d: got %h want %h", k, mem_addr, exp_addr[k]); end
      checks++; if (mem_wdata !== exp_data[k]) begin errors++; $display("FAIL drain_data_%0d: got %h want %h", k, mem_wdata, exp_data[k]); end
      tick();
      if (k == 0) begin
        checks++; if (st_ready !== 1'b1) begin errors++; $display("FAIL drain_ready_after_ack: got %b want 1", st_ready); end
      end
      if (k == 1) drive(1'b0, 32'h0, 32'h0, 3'b000);
    end
    mem_ack = 1'b0;
    checks++; if (drained !== 1'b1) begin errors++; $display("FAIL drain_done: got %b want 1", drained); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL drain_req_end: got %b want 0", mem_req); end
  endtask

  task automatic test_full_push_pop();
    logic [31:0] exp_addr [5];
    for (int i = 0; i < 5; i++) exp_addr[i] = 32'h30 + 32'(4 * i);
    mem_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, exp_addr[i], 32'hC0 + 32'(i), 3'b010);
      tick();
    end
    drive(1'b1, exp_addr[4], 32'hC4, 3'b010);
    tick();
    checks++; if (st_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %b want 0", st_ready); end
    checks++; if (mem_addr !== exp_addr[0]) begin errors++; $display("FAIL full_head: got %h want %h", mem_addr, exp_addr[0]); end
    mem_ack = 1'b1;
    tick();
    checks++; if (dut.u_fifo.count !== 3'd3) begin errors++; $display("FAIL full_refuse_count: got %0d want 3", dut.u_fifo.count); end
    checks++; if (st_ready !== 1'b1) begin errors++; $display("FAIL full_refuse_ready: got %b want 1", st_ready); end
    checks++; if (mem_addr !== exp_addr[1]) begin errors++; $display("FAIL full_next_head: got %h want %h", mem_addr, exp_addr[1]); end
    tick();
    drive(1'b0, 32'h0, 32'h0, 3'b000);
    checks++; if (dut.u_fifo.count !== 3'd3) begin errors++; $display("FAIL pushpop_count: got %0d want 3", dut.u_fifo.count); end
    for (int k = 2; k < 5; k++) begin
      checks++; if (mem_addr !== exp_addr[k]) begin errors++; $display("FAIL full_drain_addr_%0d: got %h want %h", k, mem_addr, exp_addr[k]); end
      tick();
    end
    mem_ack = 1'b0;
    checks++; if (drained !== 1'b1) begin errors++; $display("FAIL full_drained: got %b want 1", drained); end
  endtask

  task automatic test_reset_mid_req();
    mem_ack = 1'b0;
    drive(1'b1, 32'h50, 32'h1111_1111, 3'b010);
    tick();
    drive(1'b1, 32'h54, 32'h2222_2222, 3'b010);
    tick();
    drive(1'b0, 32'h0, 32'h0, 3'b000);
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL rstmid_req_before: got %b want 1", mem_req); end
    #2 rst = 1'b1;
    #1;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rstmid_req_async: got %b want 0", mem_req); end
    checks++; if (drained !== 1'b1) begin errors++; $display("FAIL rstmid_drained_async: got %b want 1", drained); end
    checks++; if (mem_be !== 4'b0000) begin errors++; $display("FAIL rstmid_be_async: got %b want 0000", mem_be); end
    @(negedge clk);
    rst = 1'b0;
    mem_ack = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rstmid_stale_%0d: got %b want 0", k, mem_req); end
    end
    mem_ack = 1'b0;
  endtask

  task automatic test_illegal_funct3();
    drive(1'b1, 32'h0, 32'hFFFF_FFFF, 3'b011);
    tick();
    drive(1'b1, 32'h0000_0005, 32'h0000_005A, 3'b000);
    checks++; if (st_err !== 1'b1) begin errors++; $display("FAIL sd_err: got %b want 1", st_err); end
    checks++; if (drained !== 1'b1) begin errors++; $display("FAIL sd_not_queued: got %b want 1", drained); end
    tick();
    drive(1'b0, 32'h0, 32'h0, 3'b000);
    checks++; if (st_err !== 1'b0) begin errors++; $display("FAIL sd_err_pulse: got %b want 0", st_err); end
    checks++; if (drained !== 1'b0) begin errors++; $display("FAIL sd_next_sb_queued: got %b want 0", drained); end
    tick();
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL sd_sb_req: got %b want 1", mem_req); end
    checks++; if (mem_addr !== 32'h0000_0004) begin errors++; $display("FAIL sd_sb_addr: got %h want 00000004", mem_addr); end
    checks++; if (mem_be !== 4'b0010) begin errors++; $display("FAIL sd_sb_be: got %b want 0010", mem_be); end
    checks++; if (mem_wdata !== 32'h5A5A_5A5A) begin errors++; $display("FAIL sd_sb_wdata: got %h want 5a5a5a5a", mem_wdata); end
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    checks++; if (drained !== 1'b1) begin errors++; $display("FAIL sd_sb_drained: got %b want 1", drained); end
  endtask

  initial begin
    test_reset();
    test_sb();
    test_sh();
    test_fill_drain();
    test_full_push_pop();
    test_reset_mid_req();
    test_illegal_funct3();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
